// File: rtl/llc_plru_ctrl.sv
// Tree pseudo-LRU replacement-state controller for the 16-way last-level cache.
// Define LLC_PLRU_INVALID_PREF_EN to prefer invalid ways during victim selection.
module llc_plru_ctrl #(
    parameter int NUM_SETS      = 16384,
    parameter int ASSOCIATIVITY = 16,
    parameter int P_LRU         = ASSOCIATIVITY - 1,
    parameter int INDEX         = $clog2(NUM_SETS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [INDEX-1:0]         req_index,
    input  logic [3:0]               req_way,
    input  logic [ASSOCIATIVITY-1:0] req_valid_mask,
    output logic                     rsp_valid,
    output logic [3:0]               rsp_way,
    output logic                     rsp_from_invalid,
    output logic                     init_done
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_READ   = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_VICTIM = 2'b01;
    localparam logic [1:0] OP_QUERY  = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    logic [1:0]       state;
    logic [INDEX-1:0] init_cnt;
    logic [1:0]       op_q;
    logic [INDEX-1:0] idx_q;
    logic [3:0]       way_q;
    logic [P_LRU-1:0] plru_mem [NUM_SETS];
    logic [P_LRU-1:0] rd_data;

    logic             wr_en;
    logic [INDEX-1:0] wr_addr;
    logic [P_LRU-1:0] wr_data;
    logic [3:0]       victim;
    logic [3:0]       rsp_way_nxt;
    logic             from_inv;

    // Walk from the root: a 0 bit points left (child 2n+1), a 1 bit points right.
    function automatic logic [3:0] tree_victim(input logic [P_LRU-1:0] v);
        int node;
        node = 0;
        for (int l = 0; l < 4; l++)
            node = v[node] ? (2 * node + 2) : (2 * node + 1);
        return 4'(node - 15);
    endfunction

    function automatic logic [P_LRU-1:0] mark_mru(input logic [P_LRU-1:0] v, input logic [3:0] w);
        logic [P_LRU-1:0] r;
        int node;
        r    = v;
        node = 0;
        for (int l = 3; l >= 0; l--) begin
            r[node] = ~w[l];
            node    = 2 * node + 1 + int'(w[l]);
        end
        return r;
    endfunction

`ifdef LLC_PLRU_INVALID_PREF_EN
    logic [ASSOCIATIVITY-1:0] mask_q;

    function automatic logic [3:0] first_invalid(input logic [ASSOCIATIVITY-1:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = ASSOCIATIVITY - 1; i >= 0; i--)
            if (!m[i]) r = 4'(i);
        return r;
    endfunction
`else
    logic unused_mask;
    assign unused_mask = ^req_valid_mask;
`endif

    assign req_ready = (state == ST_IDLE);

    always_comb begin
        victim   = tree_victim(rd_data);
        from_inv = 1'b0;
`ifdef LLC_PLRU_INVALID_PREF_EN
        if (mask_q != '1) begin
            victim   = first_invalid(mask_q);
            from_inv = (op_q == OP_VICTIM) || (op_q == OP_QUERY);
        end
`endif
        wr_en       = 1'b0;
        wr_addr     = idx_q;
        wr_data     = rd_data;
        rsp_way_nxt = victim;
        if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_cnt;
            wr_data = '0;
        end else if (state == ST_UPDATE) begin
            case (op_q)
                OP_TOUCH: begin
                    wr_en       = 1'b1;
                    wr_data     = mark_mru(rd_data, way_q);
                    rsp_way_nxt = way_q;
                end
                OP_VICTIM: begin
                    wr_en   = 1'b1;
                    wr_data = mark_mru(rd_data, victim);
                end
                OP_CLEAR: begin
                    wr_en       = 1'b1;
                    wr_data     = '0;
                    rsp_way_nxt = 4'd0;
                end
                default: ;
            endcase
        end
    end

    // Every write that reaches the array commits before the next request's READ edge, so no bypass is needed.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n)
            plru_mem[wr_addr] <= wr_data;
        rd_data <= plru_mem[idx_q];
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            op_q  <= req_op;
            idx_q <= req_index;
            way_q <= req_way;
`ifdef LLC_PLRU_INVALID_PREF_EN
            mask_q <= req_valid_mask;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_way   <= 4'd0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INDEX'(NUM_SETS - 1)) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                ST_IDLE:   if (req_valid) state <= ST_READ;
                ST_READ:   state <= ST_UPDATE;
                ST_UPDATE: begin
                    rsp_valid <= 1'b1;
                    rsp_way   <= rsp_way_nxt;
                    state     <= ST_IDLE;
                end
                default:   state <= ST_INIT;
            endcase
        end
    end

`ifdef LLC_PLRU_INVALID_PREF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            rsp_from_invalid <= 1'b0;
        else if (state == ST_UPDATE)
            rsp_from_invalid <= from_inv;
    end
`else
    assign rsp_from_invalid = 1'b0;
`endif

endmodule

// File: tb/tb_llc_plru_ctrl.sv
// Scoreboard bench for llc_plru_ctrl: a tree-PLRU reference model predicts each response,
// a negedge monitor checks way, invalid flag and latency of every rsp_valid pulse.
module tb_llc_plru_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [13:0] req_index = '0;
    logic [3:0]  req_way = '0;
    logic [15:0] req_valid_mask = '1;
    logic        rsp_valid;
    logic [3:0]  rsp_way;
    logic        rsp_from_invalid;
    logic        init_done;

    int     tests = 0;
    int     fails = 0;
    longint edgeCnt = 0;

    typedef struct {
        int     way;
        bit     inv;
        longint acc;
    } exp_t;

    exp_t        expq[$];
    logic [14:0] model[int];

    llc_plru_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_index        (req_index),
        .req_way          (req_way),
        .req_valid_mask   (req_valid_mask),
        .rsp_valid        (rsp_valid),
        .rsp_way          (rsp_way),
        .rsp_from_invalid (rsp_from_invalid),
        .init_done        (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Tree bits indexed by node number; leaf of way w is node w+15.
    function automatic int modelWalk(input logic [14:0] v);
        int n;
        n = 0;
        while (n < 15) n = v[n] ? 2 * n + 2 : 2 * n + 1;
        return n - 15;
    endfunction

    function automatic logic [14:0] modelTouch(input logic [14:0] v, input int w);
        int n;
        int p;
        n = w + 15;
        while (n > 0) begin
            p = (n - 1) / 2;
            v[p] = (n == 2 * p + 1);
            n = p;
        end
        return v;
    endfunction

    function automatic logic [14:0] modelGet(input int idx);
        if (model.exists(idx)) return model[idx];
        return 15'd0;
    endfunction

    // dirWay >= 0 overrides the model's way with a known constant.
    task automatic applyStimulus(input logic [1:0] op, input int idx, input int way,
                                 input logic [15:0] mask, input int dirWay);
        int          guard;
        logic [14:0] v;
        exp_t        e;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        req_valid      = 1'b1;
        req_op         = op;
        req_index      = 14'(idx);
        req_way        = 4'(way);
        req_valid_mask = mask;
        v     = modelGet(idx);
        e.inv = 1'b0;
        e.acc = edgeCnt + 1;
        case (op)
            2'b00: begin
                e.way      = way;
                model[idx] = modelTouch(v, way);
            end
            2'b01, 2'b10: begin
                e.way = modelWalk(v);
`ifdef LLC_PLRU_INVALID_PREF_EN
                if (mask != 16'hFFFF) begin
                    e.inv = 1'b1;
                    for (int i = 15; i >= 0; i--) if (!mask[i]) e.way = i;
                end
`endif
                if (op == 2'b01) model[idx] = modelTouch(v, e.way);
            end
            default: begin
                e.way      = 0;
                model[idx] = 15'd0;
            end
        endcase
        if (dirWay >= 0) e.way = dirWay;
        expq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitInit(input string name);
        int cycles;
        cycles = 0;
        while (!req_ready && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({name, "_cycles"}, cycles, 16384);
        checkOutput({name, "_init_done"}, init_done, 1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (expq.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_pending", expq.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rsp: got rsp_way=%0d, expected no response", rsp_way);
            end else begin
                e = expq.pop_front();
                checkOutput("rsp_way", rsp_way, e.way);
                checkOutput("rsp_from_invalid", rsp_from_invalid, e.inv);
                checkOutput("rsp_latency", edgeCnt - e.acc, 2);
            end
        end
    end

    initial begin
        int vseq[16];
        int op;
        int idx;
        logic [15:0] mask;
        vseq = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_way", rsp_way, 0);
        checkOutput("reset_from_invalid", rsp_from_invalid, 0);
        checkOutput("reset_init_done", init_done, 0);
        rst_n = 1'b1;
        waitInit("init");

        applyStimulus(2'b10, 5, 0, 16'hFFFF, 0);
        applyStimulus(2'b00, 5, 0, 16'hFFFF, 0);
        applyStimulus(2'b10, 5, 0, 16'hFFFF, 8);

        for (int i = 0; i < 16; i++)
            applyStimulus(2'b01, 7, $urandom_range(15), 16'hFFFF, vseq[i]);
        applyStimulus(2'b01, 7, 3, 16'hFFFF, 0);

        applyStimulus(2'b01, 3, 9, 16'hFFEF, -1);

        applyStimulus(2'b00, 9, 0, 16'hFFFF, 0);
        applyStimulus(2'b00, 9, 8, 16'hFFFF, 8);
        applyStimulus(2'b00, 10, 0, 16'hFFFF, 0);
        applyStimulus(2'b11, 9, 5, 16'h0000, 0);
        applyStimulus(2'b10, 9, 0, 16'hFFFF, 0);
        applyStimulus(2'b10, 10, 0, 16'hFFFF, 8);

        for (int i = 0; i < 200; i++) begin
            op  = $urandom_range(9);
            op  = (op < 4) ? 0 : (op < 7) ? 1 : (op < 9) ? 2 : 3;
            idx = ($urandom_range(7) == 0) ? $urandom_range(16383) : $urandom_range(15, 12);
            mask = '1;
            if ($urandom_range(1) == 1) mask = 16'($urandom) | 16'($urandom);
            applyStimulus(2'(op), idx, $urandom_range(15), mask, -1);
        end
        drain();

        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid      = 1'b1;
        req_op         = 2'b01;
        req_index      = 14'd7;
        req_way        = 4'd0;
        req_valid_mask = 16'hFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        checkOutput("midop_rsp_valid", rsp_valid, 0);
        checkOutput("midop_init_done", init_done, 0);
        rst_n = 1'b1;
        expq.delete();
        model.delete();
        waitInit("reinit");
        applyStimulus(2'b10, 7, 0, 16'hFFFF, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/llc_plru_ctrl.md
# llc_plru_ctrl

Replacement-state controller for the 16 MB, 16-way, 64 B-line last-level cache (16384 sets). It owns one 15-bit tree pseudo-LRU vector per set and serialises requests from the LLC lookup logic through a read-modify-write sequence. Supported requests are hit-touch, victim selection (with optional preference for invalid ways), read-only victim query and per-set clear. It sits beside the tag/MESI array and tells the lookup logic which way to fill or evict.

## Interface
- NUM_SETS, 16384, number of sets (power of two)
- ASSOCIATIVITY, 16, ways per set
- P_LRU, ASSOCIATIVITY-1 (15), PLRU tree bits per set
- INDEX, 14, set-index width, log2(NUM_SETS)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on a cycle with req_valid && req_ready
- req_op  in  2  operation: 00 TOUCH, 01 VICTIM, 10 QUERY, 11 CLEAR_SET
- req_index  in  INDEX  target set
- req_way  in  4  way to mark MRU (TOUCH only)
- req_valid_mask  in  ASSOCIATIVITY  per-way valid bits of the set (VICTIM/QUERY)
- rsp_valid  out  1  one-cycle completion pulse, one per accepted request
- rsp_way  out  4  chosen victim (VICTIM/QUERY), req_way (TOUCH), 0 (CLEAR_SET)
- rsp_from_invalid  out  1  victim chosen from an invalid way
- init_done  out  1  initial array sweep complete

## Operation
- Storage: NUM_SETS × P_LRU array with 1-cycle registered read and 1 write port.
- Tree: node n has children 2n+1 and 2n+2. Nodes 15..30 are leaves, with way = node−15.
- Victim walk: from node 0, take the left child if bit = 0, otherwise the right child.
- Update (mark way w MRU): every node on w's path is set to point away from w. The bit becomes 1 if w lies in the left subtree and 0 if it lies in the right subtree. Off-path bits are unchanged.
- All-zero vector ⇒ victim way 0.

FSM states:
- INIT: writes 0 to index init_cnt and increments it. After writing NUM_SETS−1, goes to IDLE and sets init_done = 1. init_done stays 1 until the next reset.
- IDLE: req_ready = 1. On accept, registers op, index, way and mask, issues the array read and goes to READ.
- READ: waits for read data. Goes to UPDATE.
- UPDATE: computes the result, drives rsp_valid = 1 for one cycle and goes to IDLE.
  - TOUCH: writes the updated vector.
  - VICTIM: selects a victim, marks it MRU and writes.
  - QUERY: selects a victim; no write.
  - CLEAR_SET: writes 0.

Victim selection:
- If invalid preference is compiled in and mask ≠ all-ones, the victim is the lowest-numbered way with mask bit 0, and rsp_from_invalid = 1.
- Otherwise the victim is the tree walk result, and rsp_from_invalid = 0.

General rules:
- rsp_way and rsp_from_invalid hold their last value between pulses.
- No backpressure on responses.
- req_way is ignored for VICTIM, QUERY and CLEAR_SET.
- Inputs are ignored while req_ready = 0.

## Timing
- Reset values (any cycle with rst_n = 0): state INIT, init_cnt 0, req_ready 0, rsp_valid 0, rsp_way 0, rsp_from_invalid 0, init_done 0.
- Init: the first rst_n = 1 edge writes set 0. req_ready and init_done are first high NUM_SETS cycles after reset release.
- Latency: request accepted at edge T ⇒ rsp_valid high in the cycle after edge T+2; the write commits at that same edge. req_ready is high again in the following cycle.
- Throughput: one request per 3 cycles. Back-to-back requests to the same set always see the prior write, so there is no hazard.
- Reset mid-operation: an in-flight request is dropped with no rsp_valid, and the full init sweep restarts from index 0.

## Configuration
- LLC_PLRU_INVALID_PREF_EN defined: invalid-way preference is active as described above.
- Not defined:
  - req_valid_mask is ignored.
  - The victim is always the tree walk.
  - rsp_from_invalid is tied to 0.

## Test plan
- Release reset → req_ready/init_done low for exactly 16384 cycles, then high; rsp_valid never asserts.
- QUERY set 5, mask 0xFFFF → rsp_way 0, from_invalid 0. Then TOUCH set 5 way 0, then QUERY set 5 → rsp_way 8. rsp_valid is exactly 2 cycles after each accept.
- 16 × VICTIM on set 7, mask 0xFFFF → ways 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; the 17th returns 0.
- VICTIM set 3, mask 0xFFEF → way 4, from_invalid 1 (macro defined). Without the macro → way 0, from_invalid 0.
- TOUCH set 9 ways 0 and 8, TOUCH set 10 way 0, CLEAR_SET set 9 → QUERY set 9 returns 0; QUERY set 10 returns 8.
- Accept VICTIM, drive rst_n = 0 for one cycle during READ → no rsp_valid; re-init lasts 16384 cycles; then QUERY on that set returns 0.
